// File: rtl/stack_pkg.sv
// Shared opcodes, widths and FSM state encoding for the stack sequencer.
package stack_pkg;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 8;
    localparam int unsigned FW = 4;
    localparam logic [7:0] INT_VEC_ADDR = 8'h01;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_PUSH = 3'b001;
    localparam logic [2:0] OP_POP  = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;
    localparam logic [2:0] OP_INTR = 3'b101;
    localparam logic [2:0] OP_RTI  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    typedef enum logic [3:0] {
        StIdle,
        StWr1,
        StWr2,
        StRdA1,
        StRdD1,
        StRdA2,
        StRdD2,
        StVecA,
        StVecD,
        StFin
    } state_e;

    function automatic logic op_is_valid(input logic [2:0] op);
        return (op != OP_NOP) && (op != OP_RSVD);
    endfunction

endpackage

// File: rtl/stack_addr_gen.sv
// Memory address and next-SP generation for a full-descending stack.
module stack_addr_gen #(
    parameter int unsigned   AW           = 8,
    parameter logic [AW-1:0] INT_VEC_ADDR = 8'h01
) (
    input  logic [AW-1:0] sp,
    input  logic          push,
    input  logic          pop,
    input  logic          vec,
    output logic [AW-1:0] mem_addr,
    output logic [AW-1:0] next_sp
);

    always_comb begin
        mem_addr = '0;
        next_sp  = sp;
        if (push) begin
            mem_addr = sp;
            next_sp  = sp - AW'(1);
        end else if (pop) begin
            // Pre-increment: the read hits the new SP, wrapping modulo 2^AW.
            mem_addr = sp + AW'(1);
            next_sp  = sp + AW'(1);
        end else if (vec) begin
            mem_addr = INT_VEC_ADDR;
        end
    end

endmodule

// File: rtl/stack_seq.sv
// Memory-stage sequencer for multi-cycle stack operations fed by the bypassed SP.
module stack_seq #(
    parameter int unsigned   DW           = stack_pkg::DW,
    parameter int unsigned   AW           = stack_pkg::AW,
    parameter int unsigned   FW           = stack_pkg::FW,
    parameter logic [AW-1:0] INT_VEC_ADDR = stack_pkg::INT_VEC_ADDR
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          op_valid,
    input  logic [2:0]    op_code,
    input  logic [DW-1:0] push_data,
    input  logic [DW-1:0] pc_ret,
    input  logic [DW-1:0] call_target,
    input  logic [FW-1:0] flags_in,
    input  logic [DW-1:0] sp_in,
    input  logic          sp_not_ready,
    input  logic [DW-1:0] mem_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    output logic          sp_wr_en,
    output logic [DW-1:0] sp_wr_data,
    output logic          pop_valid,
    output logic [DW-1:0] pop_data,
    output logic          pc_load,
    output logic [DW-1:0] pc_value,
    output logic          flags_load,
    output logic [FW-1:0] flags_value,
    output logic          stall_req,
    output logic          done
);

    import stack_pkg::*;

    state_e        state_q, state_d;
    logic [AW-1:0] sp_q, sp_d;
    logic [2:0]    op_q, op_d;
    logic [DW-1:0] push_q, push_d;
    logic [DW-1:0] pc_ret_q, pc_ret_d;
    logic [DW-1:0] target_q, target_d;
    logic [FW-1:0] flags_q, flags_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          ag_push, ag_pop, ag_vec;
    logic [AW-1:0] ag_addr, ag_next_sp;
    logic          accept;

    stack_addr_gen #(
        .AW          (AW),
        .INT_VEC_ADDR(INT_VEC_ADDR)
    ) u_addr_gen (
        .sp      (sp_q),
        .push    (ag_push),
        .pop     (ag_pop),
        .vec     (ag_vec),
        .mem_addr(ag_addr),
        .next_sp (ag_next_sp)
    );

    assign accept   = (state_q == StIdle) & op_valid & op_is_valid(op_code) & ~sp_not_ready;
    assign mem_addr = ag_addr;

    // Gated by rst so every output reads 0 while reset is held.
    assign stall_req = rst & ((state_q != StIdle) |
                              (op_valid & (op_code != OP_NOP) & sp_not_ready));

    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        op_d        = op_q;
        push_d      = push_q;
        pc_ret_d    = pc_ret_q;
        target_d    = target_q;
        flags_d     = flags_q;
        rdata_d     = rdata_q;
        ag_push     = 1'b0;
        ag_pop      = 1'b0;
        ag_vec      = 1'b0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_wdata   = '0;
        sp_wr_en    = 1'b0;
        sp_wr_data  = '0;
        pop_valid   = 1'b0;
        pop_data    = '0;
        pc_load     = 1'b0;
        pc_value    = '0;
        flags_load  = 1'b0;
        flags_value = '0;
        done        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    sp_d     = sp_in;
                    op_d     = op_code;
                    push_d   = push_data;
                    pc_ret_d = pc_ret;
                    target_d = call_target;
                    flags_d  = flags_in;
                    unique case (op_code)
                        OP_PUSH, OP_CALL, OP_INTR: state_d = StWr1;
                        default:                   state_d = StRdA1;
                    endcase
                end
            end
            StWr1: begin
                ag_push   = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = (op_q == OP_PUSH) ? push_q : pc_ret_q;
                sp_d      = ag_next_sp;
                state_d   = (op_q == OP_INTR) ? StWr2 : StFin;
            end
            StWr2: begin
                ag_push   = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = {{(DW-FW){1'b0}}, flags_q};
                sp_d      = ag_next_sp;
                state_d   = StVecA;
            end
            StVecA: begin
                ag_vec  = 1'b1;
                mem_re  = 1'b1;
                state_d = StVecD;
            end
            StVecD: begin
                rdata_d = mem_rdata;
                state_d = StFin;
            end
            StRdA1: begin
                ag_pop  = 1'b1;
                mem_re  = 1'b1;
                sp_d    = ag_next_sp;
                state_d = StRdD1;
            end
            StRdD1: begin
                // RTI pops flags first, then the PC on the second read.
                if (op_q == OP_RTI) begin
                    flags_d = mem_rdata[FW-1:0];
                    state_d = StRdA2;
                end else begin
                    rdata_d = mem_rdata;
                    state_d = StFin;
                end
            end
            StRdA2: begin
                ag_pop  = 1'b1;
                mem_re  = 1'b1;
                sp_d    = ag_next_sp;
                state_d = StRdD2;
            end
            StRdD2: begin
                rdata_d = mem_rdata;
                state_d = StFin;
            end
            StFin: begin
                sp_wr_en   = 1'b1;
                sp_wr_data = sp_q;
                done       = 1'b1;
                unique case (op_q)
                    OP_POP: begin
                        pop_valid = 1'b1;
                        pop_data  = rdata_q;
                    end
                    OP_CALL: begin
                        pc_load  = 1'b1;
                        pc_value = target_q;
                    end
                    OP_RET, OP_INTR: begin
                        pc_load  = 1'b1;
                        pc_value = rdata_q;
                    end
                    OP_RTI: begin
                        pc_load     = 1'b1;
                        pc_value    = rdata_q;
                        flags_load  = 1'b1;
                        flags_value = flags_q;
                    end
                    default: ;
                endcase
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            sp_q     <= '0;
            op_q     <= OP_NOP;
            push_q   <= '0;
            pc_ret_q <= '0;
            target_q <= '0;
            flags_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            sp_q     <= sp_d;
            op_q     <= op_d;
            push_q   <= push_d;
            pc_ret_q <= pc_ret_d;
            target_q <= target_d;
            flags_q  <= flags_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: doc/stack_seq.md
Name: stack_seq

Overview:
- Consumer side of the stack-pointer bypass path. Executes multi-cycle stack operations (PUSH, POP, CALL, RET, INTR, RTI) in the memory stage.
- Takes the bypassed SP (R3) and its not-ready flag, then sequences data-memory reads and writes.
- Returns the final SP for register-file writeback, plus popped data, PC and flag reloads.
- Holds the pipeline through its stall request while an operation is in progress.

Parameters:
- DW, 8, data/register width
- AW, 8, data-memory address width (equals DW; SP is a full address)
- FW, 4, flag width (Z,N,C,V)
- INT_VEC_ADDR, 8'h01, memory address holding the interrupt vector

Ports:
- clk  in  1  clock
- rst  in  1  async active-low reset
- op_valid  in  1  stack operation presented this cycle
- op_code  in  3  000 NOP, 001 PUSH, 010 POP, 011 CALL, 100 RET, 101 INTR, 110 RTI, 111 reserved
- push_data  in  DW  data for PUSH
- pc_ret  in  DW  return address for CALL/INTR
- call_target  in  DW  jump address for CALL
- flags_in  in  FW  current flags for INTR
- sp_in  in  DW  bypassed SP
- sp_not_ready  in  1  bypassed SP invalid, must wait
- mem_rdata  in  DW  data memory read data, valid 1 cycle after mem_re
- mem_addr  out  AW  data memory address
- mem_wdata  out  DW  data memory write data
- mem_we  out  1  memory write strobe
- mem_re  out  1  memory read strobe
- sp_wr_en  out  1  write sp_wr_data to R3 (1-cycle pulse)
- sp_wr_data  out  DW  updated SP
- pop_valid  out  1  pop_data valid (POP only, 1-cycle pulse)
- pop_data  out  DW  popped value
- pc_load  out  1  load pc_value into PC (1-cycle pulse)
- pc_value  out  DW  new PC
- flags_load  out  1  load flags_value (1-cycle pulse)
- flags_value  out  FW  restored flags
- stall_req  out  1  freeze upstream stages
- done  out  1  operation complete (1-cycle pulse)

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE; internal sp_q, data and op registers are cleared.
  - All outputs are 0.
  - A reset during any operation aborts it. No sp_wr_en, pc_load or done is issued for the aborted operation.
- Stack model:
  - Full-descending stack, with writes at the current SP.
  - Push: mem[SP] <= d, then SP <= SP-1.
  - Pop: SP <= SP+1, then d <= mem[SP] (new SP).
- SP arithmetic is modulo 2^DW:
  - Push at 8'h00 writes addr 00, next SP FF.
  - Pop at 8'hFF reads addr 00, next SP 00.
- stall_req = (state != IDLE) | (op_valid & op_code != NOP & sp_not_ready). It is combinational.
- Accept rule (IDLE only):
  - Accept when op_valid, op_code is a valid non-NOP, and !sp_not_ready.
  - On accept, latch sp_in into sp_q plus op_code, push_data, pc_ret, call_target and flags_in.
  - NOP and 111 are ignored and produce no pulses.
  - op_valid is ignored while not in IDLE.
- States: IDLE, WR1, WR2, RD_A1, RD_D1, RD_A2, RD_D2, VEC_A, VEC_D, FIN.
  - WRn: mem_we=1, mem_addr=sp_q, then sp_q<=sp_q-1.
  - RD_An: mem_re=1, mem_addr=sp_q+1, then sp_q<=sp_q+1.
  - RD_Dn: capture mem_rdata.
  - FIN: sp_wr_en=1, sp_wr_data=sp_q, done=1, plus any pc_load/flags_load/pop_valid. Next state IDLE.
- Sequences (cycles after the accept edge; FIN is the last cycle):
  - PUSH: WR1(push_data) -> FIN. 2 cycles.
  - POP: RD_A1 -> RD_D1 -> FIN with pop_valid. 3 cycles.
  - CALL: WR1(pc_ret) -> FIN, with pc_load and pc_value=call_target. 2 cycles.
  - RET: RD_A1 -> RD_D1 -> FIN, with pc_load and pc_value=popped. 3 cycles.
  - INTR: WR1(pc_ret) -> WR2({0,flags_in}) -> VEC_A -> VEC_D -> FIN. 5 cycles.
    - VEC_A: mem_re=1, addr=INT_VEC_ADDR; SP is unchanged.
    - FIN: pc_value = vector.
  - RTI: RD_A1 -> RD_D1 (flags = rdata[FW-1:0]) -> RD_A2 -> RD_D2 (PC) -> FIN, with flags_load and pc_load. 5 cycles.
- Outputs not named in a state are 0. mem_we and mem_re are never high together.
- FIN in cycle n permits a new accept in cycle n+1. In IDLE the unit is back-to-back capable through sp_in, with the bypass unit covering the sp_wr_en writeback.

Decomposition:
- Package stack_pkg holds:
  - Opcode localparams: OP_NOP .. OP_RTI.
  - State encoding.
  - Widths: DW, FW.
- One sub-module, stack_addr_gen. It is combinational: sp_q, push/pop, vector select -> mem_addr, next_sp.
- The FSM and datapath stay in stack_seq.

Test Plan:
- PUSH with sp_in=8'h80, push_data=8'hA5:
  - Next cycle: mem_we=1, addr=80, wdata=A5.
  - Then sp_wr_en=1, sp_wr_data=7F, done.
  - stall_req is high for 2 cycles.
- POP with sp_in=8'h7F, mem[80]=8'h3C:
  - mem_re, addr=80.
  - Then pop_valid=1, pop_data=3C, sp_wr_data=80.
- INTR then RTI:
  - INTR with pc_ret=8'h42, flags_in=4'b1010, sp=8'hF0, mem[01]=8'h20.
    - Writes 42@F0 and 0A@EF.
    - pc_value=20, sp_wr_data=EE.
  - Following RTI restores flags_value=A and pc_value=42, sp_wr_data=F0.
- Wrap-around:
  - PUSH at sp=8'h00 writes addr 00, sp_wr_data=FF.
  - POP at sp=8'hFF reads addr 00, sp_wr_data=00.
- sp_not_ready=1 for 2 cycles with op_valid PUSH:
  - stall_req=1 and no memory access.
  - The operation is accepted in the cycle sp_not_ready drops.
- Reset mid-operation: rst low during RTI state RD_A2.
  - All outputs go to 0 immediately.
  - No done or pc_load is issued, and the unit is IDLE after release.
